// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, fetch FSM states and the
// opcode type decode uses to classify fetched instructions.
package cpu_pkg;

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_INST_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_OPIMM  = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_OP     = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    function automatic logic [6:0] inst_opcode(input logic [31:0] inst);
        return inst[6:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: in-order storage of {pc, instruction} entries with count and
// synchronous flush; push into a full queue is accepted only alongside a pop.
module fetch_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_s, empty_s, do_push_s, do_pop_s;

    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign empty_s = (count_q == {CNT_W{1'b0}});

    // Pointer, count and storage update; flush overrides push and pop.
    always_comb begin
        do_pop_s  = pop & ~empty_s;
        do_push_s = push & (~full_s | do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign rdata = empty_s ? {W{1'b0}} : mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = empty_s;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, one-cycle memory response
// capture into a prefetch queue, and redirect flush. FETCH_STALL_CNT_EN adds stall_cnt.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                INST_W   = CPU_INST_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + INST_W;
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              pend_q, pend_d;
    logic              rd_en_s, push_s, pop_s, credit_ok_s, fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [CNT_W:0]    used_s;
    logic [ENT_W-1:0]  head_s;

    // A slot is reserved from request until the entry leaves the queue.
    assign used_s      = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, pend_q};
    assign credit_ok_s = (used_s < (CNT_W + 1)'(DEPTH));

    // Control FSM, request issue and fetch PC update.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = 1'b0;
        pend_pc_d = pend_pc_q;
        rd_en_s   = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = redirect_valid ? ST_FLUSH : ST_RUN;
            ST_RUN: begin
                if (redirect_valid) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                    rd_en_s = credit_ok_s;
                end
            end
            ST_FLUSH: state_d = redirect_valid ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (rd_en_s) begin
            pc_d      = pc_q + PC_ONE;
            pend_d    = 1'b1;
            pend_pc_d = pc_q;
        end else begin
            pc_d = pc_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= {ADDR_W{1'b0}};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // A response arriving during a redirect belongs to the abandoned path.
    assign push_s = pend_q & ~redirect_valid;
    assign pop_s  = ~fifo_empty_s & inst_ready;

    fetch_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push_s),
        .wdata ({pend_pc_q, imem_rdata}),
        .pop   (pop_s),
        .rdata (head_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

    assign imem_rd_en = rd_en_s;
    assign imem_addr  = pc_q;
    assign inst_valid = ~fifo_empty_s;
    assign inst_data  = head_s[INST_W-1:0];
    assign inst_pc    = head_s[ENT_W-1:INST_W];

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles the head waits on decode.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (~fifo_empty_s && !inst_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: stream-level reference model checked every
// cycle plus directed scenarios with literal expectations.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_rd_en;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [15:0] inst_pc;
    logic        inst_ready;

    logic        w_rd_en;
    logic [15:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_data;
    logic [15:0] w_pc;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] w_stall_cnt;
`endif

    int chk_cnt   = 0;
    int pass_cnt  = 0;
    int req_total = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut_w (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_rd_en     (w_rd_en),
        .imem_addr      (w_addr),
        .imem_rdata     (w_rdata),
        .redirect_valid (1'b0),
        .redirect_pc    (16'h0000),
        .inst_valid     (w_valid),
        .inst_data      (w_data),
        .inst_pc        (w_pc),
        .inst_ready     (1'b1)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt      (w_stall_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {16'h0000, a} + 32'h0000_0100;
    endfunction

    // Instruction memories: one-cycle read latency.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem_word(imem_addr);
        if (w_rd_en)    w_rdata    <= mem_word(w_addr);
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: next PC to deliver, next PC to fetch, slots in use.
    logic [15:0] m_del;
    logic [15:0] m_fetch;
    int          m_cred;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk(inst_valid === 1'b0 && imem_rd_en === 1'b0, "reset_ctrl",
                {30'h0, inst_valid, imem_rd_en}, 32'h0);
            chk(inst_data === 32'h0 && inst_pc === 16'h0, "reset_head", inst_data ^ {16'h0, inst_pc}, 32'h0);
            m_del   = 16'h0000;
            m_fetch = 16'h0000;
            m_cred  = 0;
        end else begin
            if (inst_valid) begin
                chk(inst_pc === m_del, "head_pc", {16'h0, inst_pc}, {16'h0, m_del});
                chk(inst_data === mem_word(m_del), "head_data", inst_data, mem_word(m_del));
            end
            if (m_cred == 0) chk(inst_valid === 1'b0, "no_phantom", {31'h0, inst_valid}, 32'h0);
            if (imem_rd_en) begin
                req_total++;
                chk(imem_addr === m_fetch, "fetch_addr", {16'h0, imem_addr}, {16'h0, m_fetch});
                chk(m_cred < DEPTH, "credit_limit", m_cred, DEPTH - 1);
                chk(!redirect_valid, "req_during_redirect", {31'h0, redirect_valid}, 32'h0);
            end
            if (redirect_valid) begin
                m_del   = redirect_pc;
                m_fetch = redirect_pc;
                m_cred  = 0;
            end else begin
                if (inst_valid && inst_ready) begin
                    m_del  = m_del + 16'h0001;
                    m_cred = m_cred - 1;
                end
                if (imem_rd_en) begin
                    m_fetch = m_fetch + 16'h0001;
                    m_cred  = m_cred + 1;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        chk(inst_valid === 1'b0 && imem_rd_en === 1'b0, "rst_outputs", {30'h0, inst_valid, imem_rd_en}, 32'h0);
`ifdef FETCH_STALL_CNT_EN
        chk(stall_cnt === 16'h0000, "rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
`endif
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(output bit found);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (imem_rd_en) found = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_beat(input bit need_ready, output bit found);
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (inst_valid && (inst_ready || !need_ready)) found = 1'b1;
            else tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          found;
        logic [15:0] wexp;
        int          snap;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        inst_ready     = 1'b1;
        do_reset();

        // Free-running stream from reset, plus the wrapping instance.
        wait_req(found);
        chk(found, "first_req_seen", {31'h0, found}, 32'h1);
        chk(imem_addr === 16'h0000, "first_req_addr", {16'h0, imem_addr}, 32'h0);
        chk(w_rd_en && w_addr === 16'hFFFE, "wrap_first_addr", {16'h0, w_addr}, 32'hFFFE);
        tick();
        tick();
        chk(inst_valid === 1'b1, "first_valid_n2", {31'h0, inst_valid}, 32'h1);
        chk(inst_data === 32'h0000_0100, "first_data", inst_data, 32'h0000_0100);
        chk(inst_pc === 16'h0000, "first_pc", {16'h0, inst_pc}, 32'h0);
        chk(w_valid && w_pc === 16'hFFFE, "wrap_pc0", {16'h0, w_pc}, 32'hFFFE);
        for (int k = 1; k < 4; k++) begin
            tick();
            wexp = 16'hFFFE + 16'(k);
            chk(inst_valid && inst_pc === 16'(k), "stream_1_per_cycle", {16'h0, inst_pc}, k);
            chk(w_valid && w_pc === wexp, "wrap_pc_seq", {16'h0, w_pc}, {16'h0, wexp});
            chk(w_data === mem_word(wexp), "wrap_data", w_data, mem_word(wexp));
        end
        repeat (5) tick();

        // Redirect while a response is in flight.
        wait_req(found);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        wait_beat(1'b1, found);
        chk(found, "redirect_beat_seen", {31'h0, found}, 32'h1);
        chk(inst_pc === 16'h0040, "redirect_pc", {16'h0, inst_pc}, 32'h0040);
        chk(inst_data === 32'h0000_0140, "redirect_data", inst_data, 32'h0000_0140);
        repeat (3) tick();

        // Back-to-back redirects: only the last target is delivered.
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        tick();
        redirect_pc    = 16'h0020;
        tick();
        redirect_valid = 1'b0;
        wait_beat(1'b1, found);
        chk(found, "dbl_redirect_seen", {31'h0, found}, 32'h1);
        chk(inst_pc === 16'h0020, "dbl_redirect_pc", {16'h0, inst_pc}, 32'h0020);
        repeat (5) tick();

        // Mid-stream reset, then decode stalled with a full queue.
        inst_ready = 1'b0;
        do_reset();
        snap = req_total;
        wait_req(found);
        chk(found && imem_addr === 16'h0000, "post_reset_addr", {16'h0, imem_addr}, 32'h0);
        wait_beat(1'b0, found);
        chk(found && inst_pc === 16'h0000, "stall_head_pc", {16'h0, inst_pc}, 32'h0);
        repeat (7) tick();
`ifdef FETCH_STALL_CNT_EN
        chk(stall_cnt === 16'd7, "stall_cnt_7", {16'h0, stall_cnt}, 32'd7);
`endif
        repeat (3) tick();
        chk(req_total - snap == DEPTH, "stall_req_count", req_total - snap, DEPTH);
        chk(imem_rd_en === 1'b0, "stall_no_req", {31'h0, imem_rd_en}, 32'h0);
        chk(inst_valid && inst_pc === 16'h0000 && inst_data === 32'h0000_0100, "stall_head_held",
            {16'h0, inst_pc}, 32'h0);
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk(inst_valid && inst_pc === 16'(k), "drain_in_order", {16'h0, inst_pc}, k);
            tick();
        end
        repeat (10) tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 16, instruction word-address width.
REQ-002 Parameter INST_W, default 32, instruction width.
REQ-003 Parameter DEPTH, default 4, prefetch queue entries (power of two, >=2).
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 clk  input  1  sole clock; all state on posedge clk.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 imem_rd_en  output  1  read request to instruction memory this cycle.
REQ-008 imem_addr  output  ADDR_W  word address of the request.
REQ-009 imem_rdata  input  INST_W  read data, valid exactly one cycle after imem_rd_en.
REQ-010 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  input  ADDR_W  new fetch address, sampled with redirect_valid.
REQ-012 inst_valid  output  1  queue head holds an instruction.
REQ-013 inst_data  output  INST_W  head instruction.
REQ-014 inst_pc  output  ADDR_W  word address of head instruction.
REQ-015 inst_ready  input  1  decode accepts head; transfer when inst_valid && inst_ready.

Function
REQ-016 The fetch PC SHALL drive imem_addr; it SHALL advance by 1 per issued request and wrap 2^ADDR_W-1 -> 0.
REQ-017 imem_rd_en SHALL assert only when (queue occupancy + outstanding requests) < DEPTH and redirect_valid is low.
REQ-018 Each response SHALL be written into the queue with its PC the cycle after its request; a full queue SHALL never be overrun.
REQ-019 Minimum latency: request cycle N, inst_valid high in cycle N+2 with matching inst_data/inst_pc.
REQ-020 A full, never-stalled stream SHALL sustain one instruction per cycle.
REQ-021 Queue SHALL be FIFO, in-order; simultaneous push and pop on a full queue SHALL be allowed.
REQ-022 inst_data/inst_pc SHALL remain stable while inst_valid && !inst_ready.
REQ-023 On redirect_valid: queue cleared next cycle, the in-flight response (if any) discarded, fetch PC loaded with redirect_pc, first new request issued the following cycle.
REQ-024 Redirect coinciding with a handshake: the beat counts as accepted; redirect takes priority over the push of any response in that cycle.
REQ-025 Back-to-back redirects: the last one wins; no instruction from an earlier redirect target SHALL appear.
REQ-026 Control FSM states: IDLE (post-reset, one cycle), RUN (issuing/stalled on credit), FLUSH (one cycle after redirect); IDLE->RUN, RUN->FLUSH on redirect, FLUSH->RUN, FLUSH->FLUSH on repeated redirect.

Reset
REQ-027 On rst_n low: fetch PC = RESET_PC, queue empty, outstanding = 0, FSM = IDLE, imem_rd_en = 0, inst_valid = 0, inst_data = 0, inst_pc = 0.
REQ-028 Reset asserted mid-stream SHALL discard all queued and in-flight instructions; the first request after release SHALL be RESET_PC.

Configuration
REQ-029 Macro FETCH_STALL_CNT_EN defined: adds output stall_cnt (16 bits), incrementing, saturating at 0xFFFF, each cycle inst_valid && !inst_ready; reset to 0.
REQ-030 Macro undefined: no stall_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-031 Shared package cpu_pkg SHALL hold INST_W/ADDR_W defaults, the fetch FSM state enum and the opcode typedef shared with decode.
REQ-032 The queue SHALL be a sub-module fetch_fifo (storage, pointers, count, full/empty); the FSM, credit and discard logic stay in fetch_unit.

Verification
REQ-033 Reset release, inst_ready=1, imem returns addr+0x100 -> requests at 0,1,2...; inst_valid first at cycle 2 with inst_data=0x100, inst_pc=0, then 1/cycle.
REQ-034 inst_ready=0 for 10 cycles -> exactly DEPTH=4 instructions buffered, imem_rd_en low, head held stable; release -> in-order PCs 0..3 with no gap.
REQ-035 redirect_valid with redirect_pc=0x0040 while a request is in flight -> stale response dropped, next accepted inst_pc=0x0040.
REQ-036 Redirects in two consecutive cycles to 0x0010 then 0x0020 -> no instruction from 0x0010 delivered; first delivered inst_pc=0x0020.
REQ-037 RESET_PC=0xFFFE, free-running -> inst_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-038 With FETCH_STALL_CNT_EN, 7 stalled cycles with inst_valid high -> stall_cnt=7; rst_n pulse mid-stream -> stall_cnt=0, inst_valid=0, next imem_addr=RESET_PC.
